// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI subordinate endpoint.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StComplete
    } spi_state_e;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam logic [7:0] IDLE_TX_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchronizer with one extra flop for rise/fall pulse detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI subordinate: MSB-first frames framed by active-low CS, oversampled on clk.
// Optional sticky tx underrun flag enabled by defining SPI_SLAVE_UNDERRUN_FLAG_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX     = DATA_W'(IDLE_TX_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    ,
    output logic              tx_underrun
`endif
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .reset  (reset),
        .d_i    (SCK),
        .sync_o (),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .d_i    (CS),
        .sync_o (cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .d_i    (MOSI),
        .sync_o (mosi_sync),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_fire;

    assign tx_fire = tx_valid & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) state_d = StLoad;
            end
            StLoad: begin
                // The byte is consumed even if CS rises in this same cycle.
                if (hold_full_q) begin
                    tx_shift_d  = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    tx_shift_d  = IDLE_TX;
                end
                miso_d    = tx_shift_d[DATA_W-1];
                bit_cnt_d = CNT_MAX;
                state_d   = cs_rise ? StIdle : StShift;
            end
            StShift: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (sck_fall) begin
                    rx_shift_d[bit_cnt_q] = mosi_sync;
                    if (bit_cnt_q == '0) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = StComplete;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else if (sck_rise) begin
                    miso_d = tx_shift_q[bit_cnt_q];
                end
            end
            StComplete: begin
                state_d = cs_sync ? StIdle : StLoad;
            end
            default: state_d = StIdle;
        endcase

        // Applied after LOAD so a same-cycle handshake refills the holding register.
        if (tx_fire) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        miso_oe_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= CNT_MAX;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic underrun_q, underrun_d;

    // Set has priority over the handshake clear.
    always_comb begin
        underrun_d = underrun_q;
        if (tx_fire) underrun_d = 1'b0;
        if ((state_q == StLoad) && !hold_full_q) underrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) underrun_q <= 1'b0;
        else       underrun_q <= underrun_d;
    end

    assign tx_underrun = underrun_q;
`endif

    assign MISO     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus multi-cycle corner sequences.
module tb_spi_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck, cs, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic       tx_underrun;
`endif

    spi_slave dut (
        .clk      (clk),
        .reset    (reset),
        .SCK      (sck),
        .CS       (cs),
        .MOSI     (mosi),
        .MISO     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        ,
        .tx_underrun (tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_log[$];
    int         dbl_cnt = 0;
    logic       rx_valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (rx_valid && rx_valid_prev) dbl_cnt <= dbl_cnt + 1;
        rx_valid_prev <= rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        bit ok = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        if (!ok) check("tx_load_timeout", 32'd0, 32'd1);
    endtask

    task automatic cs_assert();
        @(negedge clk);
        cs = 1'b0;
        wait_clk(HALF);
    endtask

    // CS rises one clk after the last SCK fall, so COMPLETE already sees CS high.
    task automatic cs_release();
        wait_clk(1);
        cs = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            wait_clk(HALF);
            sck  = 1'b1;
            mosi = b[7-i];
            wait_clk(HALF);
            m[7-i] = miso;
            sck    = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, output logic [7:0] m);
        cs_assert();
        xfer_bits(b, 8, m);
        cs_release();
    endtask

    typedef struct {
        logic       tx_en;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] m, m2;
        int         n0;

        vecs[0] = '{tx_en: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[1] = '{tx_en: 1'b0, tx: 8'h00, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{tx_en: 1'b1, tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{tx_en: 1'b1, tx: 8'h96, mosi: 8'h69, exp_rx: 8'h69, exp_miso: 8'h96};

        reset    = 1'b1;
        sck      = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        wait_clk(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].tx_en) begin
                load_tx(vecs[v].tx);
                check($sformatf("v%0d_tx_ready_full", v), {31'd0, tx_ready}, 32'd0);
            end
            n0 = rx_log.size();
            cs_assert();
            check($sformatf("v%0d_busy_sel", v), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_oe_sel", v), {31'd0, miso_oe}, 32'd1);
            check($sformatf("v%0d_tx_ready_after_load", v), {31'd0, tx_ready}, 32'd1);
            xfer_bits(vecs[v].mosi, 8, m);
            cs_release();
            check($sformatf("v%0d_miso", v), {24'd0, m}, {24'd0, vecs[v].exp_miso});
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_rx_pulses", v), rx_log.size() - n0, 32'd1);
            check($sformatf("v%0d_oe_idle", v), {31'd0, miso_oe}, 32'd0);
            check($sformatf("v%0d_busy_idle", v), {31'd0, busy}, 32'd0);
        end

        // Underrun: empty holding register, then a handshake clears the flag.
        frame(8'h00, m);
        check("underrun_miso", {24'd0, m}, 32'hFF);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        check("underrun_set", {31'd0, tx_underrun}, 32'd1);
`endif
        load_tx(8'h3A);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        check("underrun_clear", {31'd0, tx_underrun}, 32'd0);
`endif
        frame(8'h5C, m);
        check("after_underrun_miso", {24'd0, m}, 32'h3A);

        // Back-to-back bytes under one CS.
        load_tx(8'hC3);
        n0 = rx_log.size();
        cs_assert();
        load_tx(8'h5A);
        xfer_bits(8'h12, 8, m);
        xfer_bits(8'h34, 8, m2);
        cs_release();
        check("b2b_pulses", rx_log.size() - n0, 32'd2);
        if (rx_log.size() >= n0 + 2) begin
            check("b2b_rx0", {24'd0, rx_log[n0]}, 32'h12);
            check("b2b_rx1", {24'd0, rx_log[n0+1]}, 32'h34);
        end
        check("b2b_miso0", {24'd0, m}, 32'hC3);
        check("b2b_miso1", {24'd0, m2}, 32'h5A);

        // Abort after 4 bits.
        n0 = rx_log.size();
        cs_assert();
        xfer_bits(8'hF0, 4, m);
        cs_release();
        check("abort_no_pulse", rx_log.size() - n0, 32'd0);
        check("abort_rx_held", {24'd0, rx_data}, 32'h34);
        check("abort_oe", {31'd0, miso_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        frame(8'h81, m);
        check("post_abort_rx", {24'd0, rx_data}, 32'h81);

        // Reset mid-frame with a pending tx byte.
        cs_assert();
        load_tx(8'h77);
        xfer_bits(8'hAA, 4, m);
        @(negedge clk);
        reset = 1'b1;
        sck   = 1'b0;
        cs    = 1'b1;
        wait_clk(2);
        check("mid_reset_miso", {31'd0, miso}, 32'd0);
        check("mid_reset_oe", {31'd0, miso_oe}, 32'd0);
        check("mid_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_clk(4);
        frame(8'h7E, m);
        check("post_reset_rx", {24'd0, rx_data}, 32'h7E);
        check("post_reset_miso", {24'd0, m}, 32'hFF);

        // tx_valid held through frame start: refill lands in the holding register.
        load_tx(8'h22);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        frame(8'h55, m);
        check("hold_miso_first", {24'd0, m}, 32'h22);
        check("hold_refilled", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        frame(8'hA0, m);
        check("hold_miso_second", {24'd0, m}, 32'h11);
        check("hold_rx", {24'd0, rx_data}, 32'hA0);

        check("rx_valid_single_cycle", dbl_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
